// File: rtl/avg_pool_window_ctrl.sv
`default_nettype none
// ============================================================================
// avg_pool_window_ctrl
// Buffers KER_SIZE-1 rows of a raster pixel stream, issues non-overlapping
// KER_SIZE x KER_SIZE windows to the pool datapath and returns its results.
// Revision: 1.0
// ============================================================================
module avg_pool_window_ctrl #(
  parameter int NBITS    = 32,
  parameter int NFMAPS   = 32,
  parameter int KER_SIZE = 2,
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NBITS*NFMAPS-1:0]            in_act,
  output logic                               pool_valid,
  output logic [NBITS*KER_SIZE*KER_SIZE-1:0] pool_window [NFMAPS-1:0],
  input  logic                               pool_ready,
  input  logic [NBITS*NFMAPS-1:0]            pool_result,
  output logic                               out_valid,
  output logic [NBITS*NFMAPS-1:0]            out_act,
  input  logic                               out_ready,
  output logic                               frame_done
);

  localparam int c_PW = NBITS * NFMAPS;
  localparam int c_WW = NBITS * KER_SIZE * KER_SIZE;
  localparam int c_CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int c_KW = $clog2(KER_SIZE);
  localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W - 1);
  localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H - 1);
  localparam logic [c_KW-1:0] c_KER_LAST = c_KW'(KER_SIZE - 1);
  localparam logic [c_CW-1:0] c_KER_SPAN = c_CW'(KER_SIZE - 1);

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_CW-1:0]   r_col;
  logic [c_RW-1:0]   r_row;
  logic [c_KW-1:0]   r_wcol;
  logic [c_KW-1:0]   r_wrow;
  logic              r_last_win;
  logic              r_frame_done;
  logic [c_PW-1:0]   r_out_act;
  logic [c_PW-1:0]   r_lbuf [KER_SIZE-1][IMG_W];
  logic [c_PW-1:0]   r_prow [KER_SIZE-1];
  logic [c_WW-1:0]   r_window [NFMAPS-1:0];
  logic [c_WW-1:0]   w_window [NFMAPS-1:0];
  logic [c_PW-1:0]   w_px;
  logic [c_CW-1:0]   w_cbase;
  logic              w_accept;
  logic              w_last_wcol;
  logic              w_last_wrow;
  logic              w_complete;

  assign w_accept    = in_valid && (r_state == S_ACCEPT);
  assign w_last_wcol = (r_wcol == c_KER_LAST);
  assign w_last_wrow = (r_wrow == c_KER_LAST);
  assign w_complete  = w_accept && w_last_wcol && w_last_wrow;
  assign w_cbase     = r_col - c_KER_SPAN;

  // Window = buffered rows, partial-row register, and the completing pixel.
  always_comb begin
    w_px = '0;
    for (int ch = 0; ch < NFMAPS; ch++) begin
      w_window[ch] = '0;
      for (int wr = 0; wr < KER_SIZE; wr++) begin
        for (int wc = 0; wc < KER_SIZE; wc++) begin
          if (wr < KER_SIZE - 1) begin
            w_px = r_lbuf[wr][w_cbase + c_CW'(wc)];
          end else if (wc < KER_SIZE - 1) begin
            w_px = r_prow[wc];
          end else begin
            w_px = in_act;
          end
          w_window[ch][(wr*KER_SIZE+wc)*NBITS +: NBITS] = w_px[ch*NBITS +: NBITS];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      if (!w_last_wrow) begin
        r_lbuf[r_wrow][r_col] <= in_act;
      end else if (!w_last_wcol) begin
        r_prow[r_wcol] <= in_act;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_ACCEPT;
      r_col        <= '0;
      r_row        <= '0;
      r_wcol       <= '0;
      r_wrow       <= '0;
      r_last_win   <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_act    <= '0;
      r_window     <= '{default: '0};
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= 1'b0;
      if (w_accept) begin
        r_wcol <= w_last_wcol ? '0 : r_wcol + 1'b1;
        if (r_col == c_COL_LAST) begin
          r_col  <= '0;
          r_row  <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
          r_wrow <= w_last_wrow ? '0 : r_wrow + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_complete) begin
          r_window   <= w_window;
          r_last_win <= (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);
        end
      end
      if ((r_state == S_WAIT) && pool_ready) begin
        r_out_act <= pool_result;
      end
      if ((r_state == S_OUTPUT) && out_ready) begin
        r_frame_done <= r_last_win;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    pool_valid  = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_ACCEPT: begin
        in_ready = 1'b1;
        if (w_complete) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        pool_valid  = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (pool_ready) w_state_nxt = S_OUTPUT;
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_ACCEPT;
      end
      default: w_state_nxt = S_ACCEPT;
    endcase
  end

  assign pool_window = r_window;
  assign out_act     = r_out_act;
  assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_avg_pool_window_ctrl.sv
`default_nettype none
// ============================================================================
// tb_avg_pool_window_ctrl
// Randomized stream against a frame-image reference model plus a 7x7 instance.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_avg_pool_window_ctrl;

  localparam int NB = 8, NF = 2, K = 2, W = 4, H = 4;
  localparam int PW = NB * NF, WW = NB * K * K;
  localparam int K7 = 7, WW7 = NB * K7 * K7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, pool_valid, pool_ready;
  logic          out_valid, out_ready, frame_done;
  logic [PW-1:0] in_act, pool_result, out_act;
  logic [WW-1:0] pool_window [NF-1:0];

  logic          rst7, iv7, ir7, pv7, pr7, ov7, or7, fd7;
  logic [PW-1:0] ia7, pres7, oa7;
  logic [WW7-1:0] pw7 [NF-1:0];

  avg_pool_window_ctrl #(.NBITS(NB), .NFMAPS(NF), .KER_SIZE(K), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
    .pool_valid(pool_valid), .pool_window(pool_window), .pool_ready(pool_ready),
    .pool_result(pool_result), .out_valid(out_valid), .out_act(out_act),
    .out_ready(out_ready), .frame_done(frame_done));

  avg_pool_window_ctrl #(.NBITS(NB), .NFMAPS(NF), .KER_SIZE(K7), .IMG_W(K7), .IMG_H(K7)) dut7 (
    .clk(clk), .rst(rst7), .in_valid(iv7), .in_ready(ir7), .in_act(ia7),
    .pool_valid(pv7), .pool_window(pw7), .pool_ready(pr7),
    .pool_result(pres7), .out_valid(ov7), .out_act(oa7),
    .out_ready(or7), .frame_done(fd7));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame image + event timestamps) -------
  logic [PW-1:0] img [H][W];
  int            cyc = 0, t_c = 0, fd_cycle = -1, mr = 0, mc = 0, fd_count = 0;
  bit            seen_rst = 0, after_rst = 0, have_win = 0, busy = 0, exp_last = 0;
  logic [PW-1:0] exp_res, e_out_act;
  logic [WW-1:0] exp_win [NF-1:0];
  logic [WW-1:0] first_win [NF-1:0];
  bit            got_first = 0;
  logic [PW-1:0] hs_q [$];

  always @(negedge clk) begin
    bit e_pv, e_ov, e_ir, e_fd;
    int sum;
    logic [NB-1:0] v;
    e_pv = 0; e_ov = 0; e_ir = 0; e_fd = 0;
    if (seen_rst) begin
      e_ir = !busy;
      e_pv = have_win && (cyc == t_c + 1);
      e_ov = have_win && (cyc >= t_c + 3);
      e_fd = (cyc == fd_cycle);
      chk("in_ready", in_ready, e_ir);
      chk("pool_valid", pool_valid, e_pv);
      chk("out_valid", out_valid, e_ov);
      chk("frame_done", frame_done, e_fd);
      chk("out_act", out_act, e_out_act);
      if (e_pv) for (int ch = 0; ch < NF; ch++) chk("pool_window", pool_window[ch], exp_win[ch]);
      if (after_rst) for (int ch = 0; ch < NF; ch++) chk("reset_window", pool_window[ch], '0);
    end
    if (frame_done) fd_count++;
    if (pool_valid && !got_first) begin
      first_win = pool_window;
      got_first = 1;
    end
    after_rst = 0;
    if (rst) begin
      seen_rst = 1; after_rst = 1; have_win = 0; busy = 0;
      mr = 0; mc = 0; fd_cycle = -1; e_out_act = '0;
    end else if (seen_rst) begin
      if (have_win && cyc == t_c + 2) e_out_act = exp_res;
      if (e_ov && out_ready) begin
        hs_q.push_back(out_act);
        busy = 0; have_win = 0;
        if (exp_last) fd_cycle = cyc + 1;
      end
      if (in_valid && e_ir) begin
        img[mr][mc] = in_act;
        if ((mr % K == K - 1) && (mc % K == K - 1)) begin
          for (int ch = 0; ch < NF; ch++) begin
            sum = 0;
            for (int wr = 0; wr < K; wr++)
              for (int wc = 0; wc < K; wc++) begin
                v = img[mr-K+1+wr][mc-K+1+wc][ch*NB +: NB];
                exp_win[ch][(wr*K+wc)*NB +: NB] = v;
                sum += int'($signed(v));
              end
            exp_res[ch*NB +: NB] = NB'(sum / (K * K));
          end
          have_win = 1; busy = 1; t_c = cyc;
          exp_last = (mr == H - 1) && (mc == W - 1);
        end
        mc++;
        if (mc == W) begin
          mc = 0;
          mr = (mr + 1) % H;
        end
      end
    end
    cyc++;
  end

  // ---------------- reference truncating datapath, 1-cycle latency ---------
  bit spur = 0;
  initial begin
    bit pv, sp;
    int s;
    logic [PW-1:0] res;
    pool_ready = 0;
    pool_result = '0;
    forever begin
      @(negedge clk);
      pv = pool_valid;
      sp = spur;
      for (int ch = 0; ch < NF; ch++) begin
        s = 0;
        for (int e = 0; e < K * K; e++) s += int'($signed(pool_window[ch][e*NB +: NB]));
        res[ch*NB +: NB] = NB'(s / (K * K));
      end
      @(posedge clk);
      #1;
      pool_ready  = pv || sp;
      pool_result = pv ? res : PW'(16'hA5A5);
    end
  end

  // ---------------- stimulus ----------------------------------------------
  task automatic step(input bit v, input bit ordy, input logic [PW-1:0] px, output bit acc);
    in_valid = v; out_ready = ordy; in_act = px;
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send_px(input logic [PW-1:0] px, input int vpct, input int rpct);
    bit acc = 0;
    int guard = 0;
    while (!acc && guard < 300) begin
      step($urandom_range(99) < vpct, $urandom_range(99) < rpct, px, acc);
      guard++;
    end
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: pixel not accepted within 300 cycles");
    end
  endtask

  function automatic logic [PW-1:0] dir_px(input int p);
    int val;
    val = 4 * (p / W) + (p % W);
    return {NB'(-val), NB'(val)};
  endfunction

  task automatic idle(input int n, input bit ordy);
    bit acc;
    repeat (n) step(1'b0, ordy, '0, acc);
  endtask

  task automatic check_dir_outputs(input string tag);
    logic [PW-1:0] lit [4];
    lit[0] = 16'hFE02; lit[1] = 16'hFC04; lit[2] = 16'hF60A; lit[3] = 16'hF40C;
    chk({tag, "_count"}, hs_q.size(), 4);
    for (int i = 0; i < 4 && i < hs_q.size(); i++) chk({tag, "_act"}, hs_q[i], lit[i]);
  endtask

  bit done7 = 0;

  initial begin
    bit acc;
    rst = 1; in_valid = 0; in_act = '0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // directed frame, continuous input: packing, order, latency, frame end
    hs_q.delete(); got_first = 0;
    for (int p = 0; p < W * H; p++) send_px(dir_px(p), 100, 100);
    idle(8, 1);
    chk("first_win_ch0", first_win[0], 32'h05040100);
    chk("first_win_ch1", first_win[1], 32'hFBFCFF00);
    check_dir_outputs("frame1");
    chk("frame_done_count1", fd_count, 1);

    // backpressure on the first window of the next frame
    for (int p = 0; p < 6; p++) send_px(dir_px(p), 100, 100);
    idle(14, 0);
    idle(3, 1);
    for (int p = 6; p < W * H; p++) send_px(dir_px(p), 70, 60);
    idle(10, 1);
    chk("frame_done_count2", fd_count, 2);

    // spurious pool_ready while accepting
    spur = 1;
    step(1'b0, 1'b1, '0, acc);
    spur = 0;
    idle(4, 1);
    chk("spur_out_act", out_act, 16'hF40C);
    chk("spur_out_valid", out_valid, 0);

    // reset in the middle of row 3, then a clean frame
    for (int p = 0; p < 14; p++) send_px(dir_px(p), 80, 70);
    rst = 1;
    step(1'b1, 1'b0, '0, acc);
    rst = 0;
    hs_q.delete();
    for (int p = 0; p < W * H; p++) send_px(dir_px(p), 80, 70);
    idle(10, 1);
    check_dir_outputs("after_rst");
    chk("frame_done_count3", fd_count, 3);

    // random frames with random valid / ready
    for (int f = 0; f < 4; f++) begin
      int vp, rp;
      vp = $urandom_range(95, 40);
      rp = $urandom_range(95, 30);
      for (int p = 0; p < W * H; p++) send_px(PW'($urandom), vp, rp);
    end
    idle(10, 1);
    chk("frame_done_count_rand", fd_count, 7);

    for (int i = 0; i < 3000 && !done7; i++) @(posedge clk);
    if (!done7) begin
      n_vec++; n_err++;
      $display("FAIL k7_timeout: 7x7 sequence did not complete");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // ---------------- KER_SIZE=7 single-window frame -------------------------
  int pv7_cnt = 0;
  always @(negedge clk) begin
    if (pv7) begin
      pv7_cnt++;
      for (int ch = 0; ch < NF; ch++) begin
        logic [WW7-1:0] e7;
        e7 = {(K7*K7){NB'(ch + 1)}};
        n_vec++;
        if (pw7[ch] !== e7) begin
          n_err++;
          $display("FAIL k7_window ch%0d: got %h expected %h", ch, pw7[ch], e7);
        end
      end
    end
  end

  initial begin
    bit acc, seen;
    int guard;
    rst7 = 1; iv7 = 0; ia7 = '0; pr7 = 0; pres7 = '0; or7 = 1;
    repeat (3) @(posedge clk);
    #1 rst7 = 0;
    for (int p = 0; p < K7 * K7; p++) begin
      acc = 0; guard = 0;
      while (!acc && guard < 20) begin
        iv7 = 1; ia7 = {NB'(2), NB'(1)};
        @(negedge clk);
        acc = ir7;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!acc) begin
        n_vec++; n_err++;
        $display("FAIL k7_accept: pixel %0d not accepted", p);
      end
    end
    iv7 = 0;
    @(negedge clk);
    seen = pv7;
    chk("k7_pool_valid_latency", seen, 1);
    @(posedge clk);
    #1 pr7 = 1; pres7 = 16'h0201;
    @(posedge clk);
    #1 pr7 = 0;
    @(negedge clk);
    chk("k7_out_valid", ov7, 1);
    chk("k7_out_act", oa7, 16'h0201);
    @(negedge clk);
    chk("k7_frame_done", fd7, 1);
    repeat (3) @(negedge clk);
    chk("k7_pool_valid_count", pv7_cnt, 1);
    done7 = 1;
  end

endmodule
`default_nettype wire

// File: doc/avg_pool_window_ctrl.md
Name: avg_pool_window_ctrl

Overview:
Streaming controller that feeds the average-pooling datapath. It accepts one pixel per beat in raster order, where a pixel carries all NFMAPS channels. It buffers KER_SIZE-1 image rows and assembles non-overlapping KER_SIZE x KER_SIZE windows (stride = KER_SIZE). Each window is issued to the pool datapath, the result is captured, and it is delivered downstream with valid/ready backpressure; frame position is tracked and frame end is flagged.

Parameters:
NBITS, 32, bits per activation
NFMAPS, 32, channels per pixel
KER_SIZE, 2, window edge and stride; supported values 2 and 7
IMG_W, 8, frame width in pixels; must be a multiple of KER_SIZE
IMG_H, 8, frame height in pixels; must be a multiple of KER_SIZE

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input pixel valid
in_ready  out  1  controller accepts input pixel
in_act  in  NBITS*NFMAPS  pixel; channel i at [(i+1)*NBITS-1:i*NBITS]
pool_valid  out  1  window valid to datapath (one-cycle pulse)
pool_window  out  NBITS*KER_SIZE*KER_SIZE x [NFMAPS-1:0]  window per channel
pool_ready  in  1  datapath result valid
pool_result  in  NBITS*NFMAPS  datapath output, same packing as in_act
out_valid  out  1  pooled pixel valid
out_act  out  NBITS*NFMAPS  pooled pixel
out_ready  in  1  downstream accepts
frame_done  out  1  one-cycle pulse on handshake of the last pooled pixel of a frame

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=ACCEPT, row/col counters=0, pool_valid=0, pool_window=0, out_valid=0, out_act=0, frame_done=0, in_ready=1 from the first cycle after reset. Line buffer contents are not cleared; they are always overwritten before use.
- Input acceptance: a pixel is accepted when in_valid&&in_ready.
  - col increments on each accepted pixel. At IMG_W-1 it wraps to 0 and row increments.
  - row wraps at IMG_H-1 to 0 (next frame).
- Buffering:
  - Pixel at row r, column c with r%KER_SIZE < KER_SIZE-1 is written to line buffer slot [r%KER_SIZE][c].
  - Pixels on the last window row (r%KER_SIZE == KER_SIZE-1) with c%KER_SIZE < KER_SIZE-1 go to a partial-row register.
- Window complete: when r%KER_SIZE==KER_SIZE-1 and c%KER_SIZE==KER_SIZE-1, the window is complete on acceptance.
- Window packing: element index e = wr*KER_SIZE + wc, where wr and wc are the row and column within the window. For channel i, element e sits at pool_window[i][(e+1)*NBITS-1:e*NBITS].
- FSM:
  - ACCEPT: in_ready=1. On the completing pixel, register pool_window and go to ISSUE.
  - ISSUE: pool_valid=1 for exactly one cycle, in_ready=0, go to WAIT.
  - WAIT: in_ready=0. On pool_ready=1, capture pool_result into out_act, set out_valid=1, go to OUTPUT. There is no timeout.
  - OUTPUT: hold out_valid and out_act stable until out_ready. On the handshake, out_valid=0 and go to ACCEPT.
- frame_done: pulses in the cycle after the handshake of window (IMG_H/KER_SIZE-1, IMG_W/KER_SIZE-1).
- Latency: completing pixel accepted in cycle t -> pool_valid in t+1 -> pool_ready in t+2 (datapath has 1-cycle latency) -> out_valid in t+3. in_ready is low from t+1 until the cycle after the out handshake.
- Spurious pool_ready: pool_ready outside WAIT is ignored and does not alter out_act.
- Arithmetic: the controller performs no arithmetic on activations. Data passes bit-exact; the datapath does the averaging.
- Output order: pooled pixels are emitted in raster order of the output grid, IMG_H/KER_SIZE x IMG_W/KER_SIZE per frame.
- Back-to-back frames: the next frame starts with no idle cycles required; counters wrap naturally.
- Reset mid-operation: reset in any state returns to ACCEPT with counters at 0 and drops out_valid and pool_valid the next cycle. A partially received frame is discarded, and the next accepted pixel is treated as (0,0).

Test Plan:
- Window packing, KER_SIZE=2, IMG_W=IMG_H=4, NFMAPS=2: ch0 pixel = 4*row+col, ch1 = -(4*row+col).
  - First pool_window ch0 elements = {0,1,4,5} at e=0..3; ch1 = {0,-1,-4,-5}.
  - With a reference truncating datapath, out_act ch0 = 2, ch1 = -2.
- Output order and frame end, same frame: 4 outputs in order, ch0 = {2,4,10,12}. frame_done pulses once, after the 4th handshake only.
- Latency and stall: continuous in_valid. Check pool_valid exactly 1 cycle after the completing pixel, out_valid 2 cycles later, and in_ready=0 for the whole interval.
- Backpressure: hold out_ready=0 for 10 cycles. out_valid and out_act stay stable, in_ready stays 0, and no extra pool_valid is issued. Release -> one handshake, then in_ready=1.
- Spurious pool_ready and reset: pulse pool_ready during ACCEPT -> no out_valid. Assert rst in the middle of row 3 -> all outputs 0 next cycle. A following full frame yields the correct 4 outputs.
- KER_SIZE=7, IMG_W=IMG_H=7, all pixels ch0=1: exactly one pool_valid after 49 pixels, with all 49 elements =1.
